// File: rtl/wb_demux16_if.sv
// Write-back request channel: valid/ready handshake carrying a 4-bit
// destination index and one data word.
interface wb_demux16_if #(
    parameter int WIDTH = 16
);
    logic             wb_valid;
    logic             wb_ready;
    logic [3:0]       wb_sel;
    logic [WIDTH-1:0] wb_data;

    modport master (
        output wb_valid,
        output wb_sel,
        output wb_data,
        input  wb_ready
    );

    modport slave (
        input  wb_valid,
        input  wb_sel,
        input  wb_data,
        output wb_ready
    );
endinterface

// File: rtl/wb_demux16.sv
// Write-back demultiplexer: one-entry stage feeding a 16-entry register bank,
// with a per-register busy scoreboard and a one-hot write strobe.
module wb_demux16 #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_demux16_if.slave      wb,
    input  logic             wr_hold,
    input  logic             rsv_valid,
    input  logic [3:0]       rsv_sel,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic [WIDTH-1:0] r5,
    output logic [WIDTH-1:0] r6,
    output logic [WIDTH-1:0] r7,
    output logic [WIDTH-1:0] r8,
    output logic [WIDTH-1:0] r9,
    output logic [WIDTH-1:0] r10,
    output logic [WIDTH-1:0] r11,
    output logic [WIDTH-1:0] r12,
    output logic [WIDTH-1:0] r13,
    output logic [WIDTH-1:0] r14,
    output logic [WIDTH-1:0] r15,
    output logic [15:0]      busy,
    output logic [15:0]      wr_strobe
);

    logic [WIDTH-1:0] regs_q [16];
    logic [WIDTH-1:0] regs_d [16];
    logic             stage_v_q, stage_v_d;
    logic [3:0]       stage_sel_q, stage_sel_d;
    logic [WIDTH-1:0] stage_data_q, stage_data_d;
    logic [15:0]      busy_q, busy_d;
    logic [15:0]      strobe_q, strobe_d;
    logic             accept;
    logic             commit;
    logic [15:0]      set_vec;

    // The stage can take a new entry whenever it is empty or draining this edge.
    assign wb.wb_ready = rst_n & (~stage_v_q | ~wr_hold);
    assign accept      = wb.wb_valid & wb.wb_ready;
    assign commit      = stage_v_q & ~wr_hold;

    always_comb begin
        stage_v_d    = stage_v_q;
        stage_sel_d  = stage_sel_q;
        stage_data_d = stage_data_q;
        regs_d       = regs_q;
        strobe_d     = '0;
        set_vec      = '0;

        if (accept) begin
            stage_v_d    = 1'b1;
            stage_sel_d  = wb.wb_sel;
            stage_data_d = wb.wb_data;
        end else if (commit) begin
            stage_v_d = 1'b0;
        end

        if (commit) begin
            regs_d[stage_sel_q] = stage_data_q;
            strobe_d            = 16'h0001 << stage_sel_q;
        end

        if (rsv_valid) begin
            set_vec = 16'h0001 << rsv_sel;
        end
        // A reservation landing on the same edge as its commit keeps the bit set.
        busy_d = set_vec | (busy_q & ~strobe_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            stage_v_q    <= 1'b0;
            stage_sel_q  <= '0;
            stage_data_q <= '0;
            busy_q       <= '0;
            strobe_q     <= '0;
        end else begin
            regs_q       <= regs_d;
            stage_v_q    <= stage_v_d;
            stage_sel_q  <= stage_sel_d;
            stage_data_q <= stage_data_d;
            busy_q       <= busy_d;
            strobe_q     <= strobe_d;
        end
    end

    assign busy      = busy_q;
    assign wr_strobe = strobe_q;
    assign r0  = regs_q[0];
    assign r1  = regs_q[1];
    assign r2  = regs_q[2];
    assign r3  = regs_q[3];
    assign r4  = regs_q[4];
    assign r5  = regs_q[5];
    assign r6  = regs_q[6];
    assign r7  = regs_q[7];
    assign r8  = regs_q[8];
    assign r9  = regs_q[9];
    assign r10 = regs_q[10];
    assign r11 = regs_q[11];
    assign r12 = regs_q[12];
    assign r13 = regs_q[13];
    assign r14 = regs_q[14];
    assign r15 = regs_q[15];

endmodule

// File: tb/tb_wb_demux16.sv
// Scoreboard bench for wb_demux16: stimulus queues expected commits, a
// negedge monitor pops them on each wr_strobe and tracks a shadow bank.
module tb_wb_demux16;

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_hold = 1'b0;
    logic        rsv_valid = 1'b0;
    logic [3:0]  rsv_sel = '0;
    logic [15:0] busy, wr_strobe;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [15:0] r8, r9, r10, r11, r12, r13, r14, r15;
    logic [15:0] rr [16];
    logic [15:0] shadow [16];
    exp_t        q [$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    wb_demux16_if #(.WIDTH(16)) wb ();

    wb_demux16 #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .wb(wb.slave), .wr_hold(wr_hold),
        .rsv_valid(rsv_valid), .rsv_sel(rsv_sel),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14), .r15(r15),
        .busy(busy), .wr_strobe(wr_strobe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        rr[0] = r0;   rr[1] = r1;   rr[2] = r2;   rr[3] = r3;
        rr[4] = r4;   rr[5] = r5;   rr[6] = r6;   rr[7] = r7;
        rr[8] = r8;   rr[9] = r9;   rr[10] = r10; rr[11] = r11;
        rr[12] = r12; rr[13] = r13; rr[14] = r14; rr[15] = r15;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] s, input logic [15:0] d, input int c);
        exp_t e;
        e.sel = s; e.data = d; e.cyc = c;
        q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [3:0] s, input logic [15:0] d, input bit timed,
                        output int waits);
        wb.wb_valid = 1'b1; wb.wb_sel = s; wb.wb_data = d;
        #1;
        waits = 0;
        while (!wb.wb_ready && waits < 50) begin
            @(negedge clk); #1;
            waits++;
        end
        chk("accept_timeout", {31'd0, wb.wb_ready}, 32'd1);
        if (wb.wb_ready) push_exp(s, d, timed ? cyc + 2 : -1);
        @(negedge clk);
        wb.wb_valid = 1'b0;
    endtask

    task automatic reset_model();
        q.delete();
        for (int k = 0; k < 16; k++) shadow[k] = 16'h0000;
    endtask

    // Monitor: every strobe must match the oldest queued write; bank must match shadow.
    always @(negedge clk) begin
        if (rst_n) begin
            int bad;
            if (wr_strobe != 16'h0000) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe: got %h expected no commit", wr_strobe);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("strobe_onehot", {16'd0, wr_strobe}, {16'd0, 16'h0001 << e.sel});
                    chk("commit_data", {16'd0, rr[e.sel]}, {16'd0, e.data});
                    if (e.cyc >= 0) chk("commit_latency", cyc, e.cyc);
                    shadow[e.sel] = e.data;
                end
            end
            bad = 0;
            for (int k = 0; k < 16; k++) if (rr[k] !== shadow[k]) bad++;
            chk("regs_vs_model_mismatches", bad, 0);
        end
    end

    initial begin
        int w;
        logic [15:0] r5_before;
        wb.wb_valid = 1'b0; wb.wb_sel = '0; wb.wb_data = '0;
        reset_model();

        // Reset state
        #3;
        chk("ready_in_reset", {31'd0, wb.wb_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_busy", {16'd0, busy}, 32'h0);
        chk("reset_strobe", {16'd0, wr_strobe}, 32'h0);
        chk("reset_ready", {31'd0, wb.wb_ready}, 32'd1);
        for (int k = 0; k < 16; k++) chk("reset_reg", {16'd0, rr[k]}, 32'h0);
        @(negedge clk);

        // Back-to-back sweep of all 16 indices
        for (int k = 0; k < 16; k++) begin
            send(4'(k), 16'h0100 + 16'(k), 1'b1, w);
            chk("sweep_no_stall", w, 0);
        end
        @(negedge clk);
        for (int k = 0; k < 16; k++) chk("sweep_reg", {16'd0, rr[k]}, {16'd0, 16'h0100 + 16'(k)});

        // Hold/stall
        wr_hold = 1'b1;
        send(4'd5, 16'hBEEF, 1'b0, w);
        #1;
        chk("hold_ready_low", {31'd0, wb.wb_ready}, 32'd0);
        r5_before = r5;
        wb.wb_valid = 1'b1; wb.wb_sel = 4'd6; wb.wb_data = 16'h1234;
        repeat (3) begin
            @(negedge clk); #1;
            chk("hold_ready_stalled", {31'd0, wb.wb_ready}, 32'd0);
            chk("hold_r5_unchanged", {16'd0, r5}, {16'd0, r5_before});
        end
        wr_hold = 1'b0;
        #1;
        chk("release_ready", {31'd0, wb.wb_ready}, 32'd1);
        push_exp(4'd6, 16'h1234, cyc + 2);
        @(negedge clk);
        wb.wb_valid = 1'b0;
        chk("release_r5", {16'd0, r5}, 32'hBEEF);
        chk("release_r6_pending", {16'd0, r6}, 32'h0106);
        @(negedge clk);
        chk("release_r6", {16'd0, r6}, 32'h1234);

        // Scoreboard
        rsv_valid = 1'b1; rsv_sel = 4'd3;
        @(negedge clk);
        rsv_valid = 1'b0;
        chk("busy_reserve", {16'd0, busy}, 32'h0008);
        send(4'd3, 16'h3333, 1'b1, w);
        chk("busy_staged", {16'd0, busy}, 32'h0008);
        @(negedge clk);
        chk("busy_cleared", {16'd0, busy}, 32'h0000);
        send(4'd3, 16'h4444, 1'b1, w);
        rsv_valid = 1'b1; rsv_sel = 4'd3;
        @(negedge clk);
        chk("busy_set_wins", {16'd0, busy}, 32'h0008);
        @(negedge clk);
        rsv_valid = 1'b0;
        chk("busy_rereserve", {16'd0, busy}, 32'h0008);

        // Isolation
        send(4'd9, 16'hFFFF, 1'b1, w);
        @(negedge clk);
        chk("iso_strobe_on", {16'd0, wr_strobe}, 32'h0200);
        chk("iso_r9", {16'd0, r9}, 32'hFFFF);
        chk("iso_r8", {16'd0, r8}, 32'h0108);
        chk("iso_r10", {16'd0, r10}, 32'h010A);
        @(negedge clk);
        chk("iso_strobe_off", {16'd0, wr_strobe}, 32'h0000);

        // Async reset with a staged, uncommitted entry
        wr_hold = 1'b1;
        send(4'd7, 16'hAAAA, 1'b0, w);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_r7", {16'd0, r7}, 32'h0);
        chk("arst_r9", {16'd0, r9}, 32'h0);
        chk("arst_busy", {16'd0, busy}, 32'h0);
        chk("arst_ready", {31'd0, wb.wb_ready}, 32'd0);
        reset_model();
        #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("arst_ready_after", {31'd0, wb.wb_ready}, 32'd1);
        wr_hold = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_r7_discarded", {16'd0, r7}, 32'h0);
        chk("arst_no_strobe", {16'd0, wr_strobe}, 32'h0);

        begin
            int n;
            n = 0;
            while (q.size() != 0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("queue_drained", q.size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
